sfu_tile_seq: RTL and testbench
===============================

# sfu_tile_seq

Tile sequencer for the SFU row.
- Per output tile, it clears the SFU row, then streams `kij_len × nij_len` partial-sum words from the output FIFO into it.
- It then drains the `nij_len` accumulated results to output SRAM, with addresses taken from a per-tile base.
- It sits between the output FIFO of the systolic array, the SFU row, and the output SRAM write port.
- It is started once per tile by the top-level controller.

## Interface

Parameters:
- `kij_len`, 9, kernel positions accumulated per output.
- `nij_len`, 36, output positions per tile.
- `addr_w`, 8, output SRAM address width.

Ports (reset reset, synchronous, active-high; clock clk):
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous active-high reset.
- `start`  in  1  begin one tile; sampled only in IDLE.
- `out_base`  in  `addr_w`  SRAM base address for this tile; latched when `start` is accepted.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a tile finishes.
- `ofifo_valid`  in  1  output FIFO non-empty; first-word fall-through.
- `ofifo_rd`  out  1  FIFO pop.
- `sfu_reset`  out  1  reset to SFU row.
- `sfu_i_valid`  out  1  SFU accumulate strobe.
- `sfu_o_valid`  in  1  SFU row results valid.
- `wr_en`  out  1  SRAM write enable.
- `wr_addr`  out  `addr_w`  SRAM write address.
- `kij_idx`  out  `$clog2(kij_len)`  current kernel index, for debug and address generation upstream.
- `nij_idx`  out  `$clog2(nij_len)`  current position index within a kij pass.

## Operation

States: IDLE, CLR, ACC, DRAIN, DONE.

**IDLE**
- On `start`=1: latch `out_base` into `base_q`, zero all counters, go to CLR.
- `start` is ignored in every other state.

**CLR**
- Lasts exactly 1 cycle, then goes to ACC.
- `sfu_reset` = `reset` | (state==CLR), combinational. This also zeroes the SFU row's internal read counter, so the row and this block start each tile aligned.

**ACC**
- `ofifo_rd` = `sfu_i_valid` = (state==ACC) & `ofifo_valid`, combinational.
- Each accepted word advances `nij_idx`.
- When `nij_idx`==`nij_len`-1 on an accept: `nij_idx`→0 and `kij_idx` increments.
- The accept with `kij_idx`==`kij_len`-1 and `nij_idx`==`nij_len`-1 is the last one: go to DRAIN; counters stay at terminal values, then are cleared on DRAIN entry.
- FIFO bubbles (`ofifo_valid`=0) stall the counters. No timeout.

**DRAIN**
- `wr_en` = (state==DRAIN) & `sfu_o_valid`, combinational.
- `wr_addr` = `base_q` + `drain_cnt`, modulo 2^`addr_w` (wrap, no saturation).
- `drain_cnt` increments on each `wr_en`. This matches the SFU row's own counter, which advances on the same `sfu_o_valid` cycles.
- After `nij_len` writes, go to DONE.
- If `sfu_o_valid` drops mid-drain, the block holds; no write occurs that cycle.
- `ofifo_rd` and `sfu_i_valid` are 0.

**DONE**
- `done`=1 for exactly 1 cycle, then go to IDLE.

**Reset**
- Any cycle with `reset`=1 forces IDLE and zeroes all counters and `base_q`. This includes reset mid-ACC or mid-DRAIN.

**Output values in reset/IDLE**
- 0: `busy`, `done`, `ofifo_rd`, `sfu_i_valid`, `wr_en`, `wr_addr`, `kij_idx`, `nij_idx`.
- `sfu_reset` follows `reset` (1 while reset is asserted, 0 in IDLE otherwise).

## Timing

- `start` sampled at edge E0 → CLR during cycle 1 (`sfu_reset`=1) → ACC from cycle 2.
- With `ofifo_valid` held at 1, ACC lasts exactly `kij_len`·`nij_len` cycles: 324 at defaults. The first pop happens in cycle 2.
- DRAIN with `sfu_o_valid` continuously 1 lasts `nij_len` cycles. `done` is asserted the cycle after the last write.
- Minimum tile latency, `start` to `done`: 2 + 324 + `sfu_o_valid` wait + 36 cycles.
- `busy` rises the cycle after `start` is accepted and falls the cycle after `done`.
- Back-to-back: `start` may be held or re-pulsed during DONE; it is only honoured once IDLE is reached. Minimum gap is 1 IDLE cycle.
- Pop/accumulate outputs are combinational from `ofifo_valid`/`sfu_o_valid` and the registered state. No output is registered beyond the state and counters.

## Test plan

1. **Nominal tile.** `out_base`=0x10, FIFO always valid, `sfu_o_valid` high from DRAIN entry.
   - Required: exactly 324 `ofifo_rd` pulses.
   - Required: `kij_idx` steps 0..8, each held for 36 accepts.
   - Required: 36 writes to addresses 0x10..0x33, then a single `done` pulse.
2. **FIFO bubbles.** `ofifo_valid` toggles 1,0,1,0.
   - Required: still 324 accepts total.
   - Required: no `sfu_i_valid` when `ofifo_valid`=0; counters frozen during bubbles.
3. **SFU valid gaps.** `sfu_o_valid` drops for 3 cycles mid-DRAIN.
   - Required: exactly 36 writes, contiguous addresses, and no `wr_en` during the gap.
4. **Wrap.** `out_base`=0xF0, `addr_w`=8.
   - Required: writes go to 0xF0..0xFF, then 0x00..0x13.
5. **Reset mid-ACC.** Assert `reset` after 100 accepts, then start a new tile.
   - Required: IDLE with all outputs 0 during reset.
   - Required: the new tile completes with a full 324 accepts and a CLR pulse on `sfu_reset`.
6. **Start while busy, then back-to-back tiles.**
   - Drive `start` during ACC with a different `out_base`. Required: ignored, and the original base is used.
   - Drive a second `start` one cycle after `done`, with base 0x40. Required: a second tile with writes to 0x40..0x63.

Source files
------------

// File: rtl/sfu_tile_seq.sv
// Per-tile sequencer for the SFU row: clear, accumulate kij_len*nij_len FIFO words,
// then drain nij_len results to output SRAM at base_q + drain index.
module sfu_tile_seq #(
  parameter int kij_len = 9,
  parameter int nij_len = 36,
  parameter int addr_w  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [addr_w-1:0]            out_base,
  output logic                         busy,
  output logic                         done,
  input  logic                         ofifo_valid,
  output logic                         ofifo_rd,
  output logic                         sfu_reset,
  output logic                         sfu_i_valid,
  input  logic                         sfu_o_valid,
  output logic                         wr_en,
  output logic [addr_w-1:0]            wr_addr,
  output logic [$clog2(kij_len)-1:0]   kij_idx,
  output logic [$clog2(nij_len)-1:0]   nij_idx
);
  localparam int KW = $clog2(kij_len);
  localparam int NW = $clog2(nij_len);
  localparam logic [KW-1:0] KLAST = KW'(kij_len - 1);
  localparam logic [NW-1:0] NLAST = NW'(nij_len - 1);

  typedef enum logic [2:0] {IDLE, CLR, ACC, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [addr_w-1:0] base_q, base_d;
  logic [KW-1:0]     kij_q, kij_d;
  logic [NW-1:0]     nij_q, nij_d;
  logic [NW-1:0]     drain_q, drain_d;
  logic              acc_take, drn_take;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      kij_q   <= '0;
      nij_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      kij_q   <= kij_d;
      nij_q   <= nij_d;
      drain_q <= drain_d;
    end
  end

  // Outputs are forced quiet during a reset cycle, since the state register
  // only returns to IDLE at the following edge.
  assign acc_take    = !reset && (state_q == ACC) && ofifo_valid;
  assign drn_take    = !reset && (state_q == DRAIN) && sfu_o_valid;
  assign ofifo_rd    = acc_take;
  assign sfu_i_valid = acc_take;
  assign wr_en       = drn_take;
  assign sfu_reset   = reset || (state_q == CLR);
  assign busy        = !reset && (state_q != IDLE);
  assign done        = !reset && (state_q == DONE);
  assign wr_addr     = busy ? (base_q + addr_w'(drain_q)) : '0;
  assign kij_idx     = reset ? '0 : kij_q;
  assign nij_idx     = reset ? '0 : nij_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    kij_d   = kij_q;
    nij_d   = nij_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: if (start) begin
        base_d  = out_base;
        kij_d   = '0;
        nij_d   = '0;
        drain_d = '0;
        state_d = CLR;
      end
      CLR: state_d = ACC;
      ACC: if (acc_take) begin
        if (nij_q == NLAST) begin
          nij_d = '0;
          if (kij_q == KLAST) begin
            kij_d   = '0;
            drain_d = '0;
            state_d = DRAIN;
          end else begin
            kij_d = kij_q + 1'b1;
          end
        end else begin
          nij_d = nij_q + 1'b1;
        end
      end
      DRAIN: if (drn_take) begin
        if (drain_q == NLAST) begin
          drain_d = '0;
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sfu_tile_seq.sv
// Scoreboard bench for sfu_tile_seq: expected write addresses are queued per tile
// and popped on each wr_en; accept indices are checked against the accept count.
module tb_sfu_tile_seq;
  localparam int KL = 9, NL = 36, AW = 8, TILE = KL * NL;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [AW-1:0] out_base = '0;
  logic          busy, done, ofifo_rd, sfu_reset, sfu_i_valid, wr_en;
  logic          ofifo_valid = 1'b1, sfu_o_valid = 1'b1;
  logic [AW-1:0] wr_addr;
  logic [3:0]    kij_idx;
  logic [5:0]    nij_idx;

  int n_chk = 0, n_pass = 0;
  int tile_acc = 0, tile_wr = 0, tile_clr = 0, done_cnt = 0;
  int bub_en = 0, gap_en = 0, gap_left = 0;
  bit gap_done = 1'b0;
  logic [AW-1:0] exp_q[$];

  sfu_tile_seq #(.kij_len(KL), .nij_len(NL), .addr_w(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .out_base(out_base),
    .busy(busy), .done(done), .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
    .sfu_reset(sfu_reset), .sfu_i_valid(sfu_i_valid), .sfu_o_valid(sfu_o_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .kij_idx(kij_idx), .nij_idx(nij_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // FIFO / SFU-valid pattern generator
  always @(posedge clk) begin
    #1;
    ofifo_valid = (bub_en != 0) ? ~ofifo_valid : 1'b1;
    if (gap_en != 0 && !gap_done && tile_wr == 10) begin
      gap_left = 3;
      gap_done = 1'b1;
    end
    if (gap_left > 0) begin
      sfu_o_valid = 1'b0;
      gap_left--;
    end else begin
      sfu_o_valid = 1'b1;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (sfu_reset) tile_clr++;
      if (!ofifo_valid) begin
        chk("rd_in_bubble", ofifo_rd, 0);
        chk("ival_in_bubble", sfu_i_valid, 0);
        if (busy && tile_acc < TILE) chk("nij_frozen", nij_idx, tile_acc % NL);
      end
      if (ofifo_rd) begin
        chk("ival_eq_rd", sfu_i_valid, 1);
        chk("kij_idx", kij_idx, tile_acc / NL);
        chk("nij_idx", nij_idx, tile_acc % NL);
        tile_acc++;
      end
      if (!sfu_o_valid) chk("wr_in_gap", wr_en, 0);
      if (wr_en) begin
        if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("wr_addr", wr_addr, exp_q.pop_front());
        tile_wr++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic idle_outputs(input string tag, input logic exp_sfu_rst);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd"}, ofifo_rd, 0);
    chk({tag, "_ival"}, sfu_i_valid, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_kij"}, kij_idx, 0);
    chk({tag, "_nij"}, nij_idx, 0);
    chk({tag, "_sfu_reset"}, sfu_reset, exp_sfu_rst);
  endtask

  task automatic run_tile(input logic [AW-1:0] base, input int bub, input int gap, input int poke);
    int t;
    for (int i = 0; i < NL; i++) exp_q.push_back(AW'(base + AW'(i)));
    bub_en = bub; gap_en = gap; gap_done = 1'b0;
    tile_acc = 0; tile_wr = 0; tile_clr = 0; done_cnt = 0;
    @(posedge clk); #1 start = 1'b1; out_base = base;
    @(negedge clk);
    chk("pre_start_busy", busy, 0);
    chk("pre_start_done", done, 0);
    @(posedge clk); #1 start = 1'b0; out_base = 8'hAA;
    @(negedge clk);
    chk("clr_sfu_reset", sfu_reset, 1);
    chk("clr_busy", busy, 1);
    chk("clr_no_rd", ofifo_rd, 0);
    if (poke != 0) begin
      repeat (50) @(posedge clk);
      #1 start = 1'b1; out_base = 8'h77;
      @(posedge clk); #1 start = 1'b0;
    end
    t = 0;
    while (!done && t < 3000) begin @(negedge clk); t++; end
    #1;
    if (!done) chk("tile_timeout", 0, 1);
    chk("done_busy", busy, 1);
    chk("tile_accepts", tile_acc, TILE);
    chk("tile_writes", tile_wr, NL);
    chk("tile_clr_pulses", tile_clr, 1);
    chk("tile_done_pulses", done_cnt, 1);
    chk("tile_queue_left", exp_q.size(), 0);
    bub_en = 0; gap_en = 0;
  endtask

  task automatic reset_mid();
    int t;
    tile_acc = 0; tile_wr = 0; tile_clr = 0; done_cnt = 0;
    @(posedge clk); #1 start = 1'b1; out_base = 8'h55;
    @(posedge clk); #1 start = 1'b0;
    t = 0;
    while (tile_acc < 100 && t < 1000) begin @(negedge clk); t++; end
    chk("mid_reached_100", (tile_acc >= 100) ? 1 : 0, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    idle_outputs("mid_rst", 1'b1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    idle_outputs("mid_idle", 1'b0);
    chk("mid_no_writes", tile_wr, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    idle_outputs("rst", 1'b1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    idle_outputs("idle", 1'b0);

    run_tile(8'h10, 0, 0, 0);  // nominal
    run_tile(8'h20, 1, 0, 0);  // FIFO bubbles
    run_tile(8'h30, 0, 1, 0);  // sfu_o_valid gap mid-drain
    run_tile(8'hF0, 0, 0, 0);  // address wrap
    reset_mid();
    run_tile(8'h08, 0, 0, 0);  // full tile after mid-ACC reset
    run_tile(8'h60, 0, 0, 1);  // start during ACC ignored
    run_tile(8'h40, 0, 0, 0);  // back-to-back, one cycle after done

    @(negedge clk);
    chk("final_done_low", done, 0);
    chk("final_busy_low", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
